// File: rtl/decode_stage.sv
// RV32I decode stage: decodes ALU-class instructions and presents them to
// execute through a registered two-entry skid buffer.

package pkg_config;
  localparam int DATA_WIDTH = 32;
  localparam logic [5:0] OP_ALU_ADD  = 6'h01;
  localparam logic [5:0] OP_ALU_SUB  = 6'h02;
  localparam logic [5:0] OP_ALU_SLL  = 6'h03;
  localparam logic [5:0] OP_ALU_SLT  = 6'h04;
  localparam logic [5:0] OP_ALU_SLTU = 6'h05;
  localparam logic [5:0] OP_ALU_XOR  = 6'h06;
  localparam logic [5:0] OP_ALU_SRL  = 6'h07;
  localparam logic [5:0] OP_ALU_SRA  = 6'h08;
  localparam logic [5:0] OP_ALU_OR   = 6'h09;
  localparam logic [5:0] OP_ALU_AND  = 6'h0A;
endpackage

module decode_stage
  import pkg_config::*;
#(
  parameter int DATA_WIDTH   = pkg_config::DATA_WIDTH,
  parameter int ALU_OP_WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [DATA_WIDTH-1:0]   instr_i,
  input  logic [DATA_WIDTH-1:0]   pc_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  output logic [4:0]              rd_addr_o,
  output logic [DATA_WIDTH-1:0]   imm_o,
  output logic [1:0]              alu_src_a_o,
  output logic                    alu_src_b_imm_o,
  output logic                    reg_write_o,
  output logic                    is_load_o,
  output logic                    is_store_o,
  output logic                    illegal_o,
  output logic [DATA_WIDTH-1:0]   pc_o
);

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [DATA_WIDTH-1:0]   imm;
    logic [1:0]              src_a;
    logic                    src_b_imm;
    logic                    reg_write;
    logic                    is_load;
    logic                    is_store;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   pc;
  } entry_t;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(OP_ALU_ADD);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [DATA_WIDTH-1:0] i_imm;
  logic [DATA_WIDTH-1:0] s_imm;
  logic [DATA_WIDTH-1:0] u_imm;
  logic [DATA_WIDTH-1:0] shamt_imm;

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q, ready_d;
  logic   in_fire;
  logic   out_fire;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign i_imm     = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign s_imm     = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign u_imm     = {{(DATA_WIDTH-32){instr_i[31]}}, instr_i[31:12], 12'b0};
  assign shamt_imm = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};

  assign in_fire  = instr_valid_i && ready_q;
  assign out_fire = main_valid_q && ex_ready_i;

  // Shared funct3 -> ALU op mapping; alt selects SUB/SRA variants
  function automatic logic [ALU_OP_WIDTH-1:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [5:0] op;
    case (f3)
      3'b000:  op = alt ? OP_ALU_SUB : OP_ALU_ADD;
      3'b001:  op = OP_ALU_SLL;
      3'b010:  op = OP_ALU_SLT;
      3'b011:  op = OP_ALU_SLTU;
      3'b100:  op = OP_ALU_XOR;
      3'b101:  op = alt ? OP_ALU_SRA : OP_ALU_SRL;
      3'b110:  op = OP_ALU_OR;
      default: op = OP_ALU_AND;
    endcase
    return ALU_OP_WIDTH'(op);
  endfunction

  // Decode the incoming instruction word into an entry; illegal words are neutralised
  always_comb begin
    logic legal;
    logic alt;
    dec           = '0;
    dec.alu_op    = ALU_ADD;
    dec.rs1       = instr_i[19:15];
    dec.rs2       = instr_i[24:20];
    dec.rd        = instr_i[11:7];
    dec.pc        = pc_i;
    legal         = 1'b1;
    alt           = (funct7 == 7'b0100000);
    case (opcode)
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = f3_op(funct3, alt);
        legal         = (funct7 == 7'b0) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        if (funct3 == 3'b001) begin
          dec.alu_op = f3_op(funct3, 1'b0);
          dec.imm    = shamt_imm;
          legal      = (funct7 == 7'b0);
        end else if (funct3 == 3'b101) begin
          dec.alu_op = f3_op(funct3, alt);
          dec.imm    = shamt_imm;
          legal      = (funct7 == 7'b0) || alt;
        end else begin
          dec.alu_op = f3_op(funct3, 1'b0);
          dec.imm    = i_imm;
        end
      end
      7'b0000011: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.is_load   = 1'b1;
        dec.imm       = i_imm;
      end
      7'b0100011: begin
        dec.src_b_imm = 1'b1;
        dec.is_store  = 1'b1;
        dec.imm       = s_imm;
      end
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.src_a     = 2'b10;
        dec.imm       = u_imm;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.src_a     = 2'b01;
        dec.imm       = u_imm;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.alu_op    = ALU_ADD;
      dec.imm       = '0;
      dec.src_a     = 2'b00;
      dec.src_b_imm = 1'b0;
    end
  end

  // Skid buffer next state: refill main from skid or input when it empties, else park input in skid
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_d = dec;
        end
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_d = dec;
        end
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  // State registers with asynchronous reset to an empty, ready buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
      main_q        <= '0;
      main_q.alu_op <= ALU_ADD;
      skid_q        <= '0;
      skid_q.alu_op <= ALU_ADD;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign instr_ready_o   = ready_q;
  assign ex_valid_o      = main_valid_q;
  assign alu_op_o        = main_q.alu_op;
  assign rs1_addr_o      = main_q.rs1;
  assign rs2_addr_o      = main_q.rs2;
  assign rd_addr_o       = main_q.rd;
  assign imm_o           = main_q.imm;
  assign alu_src_a_o     = main_q.src_a;
  assign alu_src_b_imm_o = main_q.src_b_imm;
  assign reg_write_o     = main_q.reg_write;
  assign is_load_o       = main_q.is_load;
  assign is_store_o      = main_q.is_store;
  assign illegal_o       = main_q.illegal;
  assign pc_o            = main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode vectors, skid buffer ordering,
// flush and asynchronous reset.

module tb_decode_stage;

  localparam logic [31:0] ADD  = 32'h01;
  localparam logic [31:0] SUB  = 32'h02;
  localparam logic [31:0] SRA  = 32'h08;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        exValid;
  logic        exReady;
  logic [5:0]  aluOp;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [4:0]  rdAddr;
  logic [31:0] imm;
  logic [1:0]  srcA;
  logic        srcBImm;
  logic        regWrite;
  logic        isLoad;
  logic        isStore;
  logic        illegal;
  logic [31:0] pcOut;

  int numChecks = 0;
  int numFails  = 0;

  decode_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .instr_valid_i   (instrValid),
    .instr_ready_o   (instrReady),
    .instr_i         (instr),
    .pc_i            (pc),
    .ex_valid_o      (exValid),
    .ex_ready_i      (exReady),
    .alu_op_o        (aluOp),
    .rs1_addr_o      (rs1Addr),
    .rs2_addr_o      (rs2Addr),
    .rd_addr_o       (rdAddr),
    .imm_o           (imm),
    .alu_src_a_o     (srcA),
    .alu_src_b_imm_o (srcBImm),
    .reg_write_o     (regWrite),
    .is_load_o       (isLoad),
    .is_store_o      (isStore),
    .illegal_o       (illegal),
    .pc_o            (pcOut)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one word for a single cycle, then sample just after the accepting edge
  task automatic applyStimulus(input logic [31:0] word, input logic [31:0] addr);
    instr      = word;
    pc         = addr;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
  endtask

  task automatic checkDecode(input string tag, input logic [31:0] expOp, input logic [31:0] expImm,
                             input logic [31:0] expSrcA, input logic expSrcB, input logic expWr,
                             input logic expLd, input logic expSt, input logic expIll);
    checkOutput({tag, ".valid"}, 32'(exValid), 32'd1);
    checkOutput({tag, ".op"}, 32'(aluOp), expOp);
    checkOutput({tag, ".imm"}, imm, expImm);
    checkOutput({tag, ".srcA"}, 32'(srcA), expSrcA);
    checkOutput({tag, ".srcB"}, 32'(srcBImm), 32'(expSrcB));
    checkOutput({tag, ".wr"}, 32'(regWrite), 32'(expWr));
    checkOutput({tag, ".ld"}, 32'(isLoad), 32'(expLd));
    checkOutput({tag, ".st"}, 32'(isStore), 32'(expSt));
    checkOutput({tag, ".ill"}, 32'(illegal), 32'(expIll));
  endtask

  initial begin
    logic [31:0] seen [$];
    logic        accepted;

    rst        = 1'b1;
    flush      = 1'b0;
    instrValid = 1'b0;
    instr      = '0;
    pc         = '0;
    exReady    = 1'b1;
    #12;
    checkOutput("rst.valid", 32'(exValid), 32'd0);
    checkOutput("rst.ready", 32'(instrReady), 32'd1);
    checkOutput("rst.op", 32'(aluOp), ADD);
    checkOutput("rst.imm", imm, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // add x3,x1,x2
    applyStimulus(32'h002081B3, 32'h0000_0040);
    checkDecode("add", ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("add.rs1", 32'(rs1Addr), 32'd1);
    checkOutput("add.rs2", 32'(rs2Addr), 32'd2);
    checkOutput("add.rd", 32'(rdAddr), 32'd3);
    checkOutput("add.pc", pcOut, 32'h40);

    // sub x5,x6,x7
    applyStimulus(32'h407302B3, 32'h44);
    checkDecode("sub", SUB, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sub.rd", 32'(rdAddr), 32'd5);

    // OP with funct7 0100001
    applyStimulus(32'h42208033, 32'h48);
    checkDecode("badf7", ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("badf7.rs1", 32'(rs1Addr), 32'd1);

    // addi x1,x0,-1
    applyStimulus(32'hFFF00093, 32'h4C);
    checkDecode("addi", ADD, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // srai x2,x2,4
    applyStimulus(32'h40415113, 32'h50);
    checkDecode("srai", SRA, 32'h4, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("srai.rd", 32'(rdAddr), 32'd2);

    // slli with funct7 0000001
    applyStimulus(32'h02009093, 32'h54);
    checkDecode("slliBad", ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // lui x4,0x12345
    applyStimulus(32'h12345237, 32'h58);
    checkDecode("lui", ADD, 32'h1234_5000, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lui.rd", 32'(rdAddr), 32'd4);

    // auipc x4,0x12345 at pc 0x100
    applyStimulus(32'h12345217, 32'h100);
    checkDecode("auipc", ADD, 32'h1234_5000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("auipc.pc", pcOut, 32'h100);

    // lw x5,8(x1)
    applyStimulus(32'h0080A283, 32'h104);
    checkDecode("lw", ADD, 32'd8, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // sw x2,-4(x1)
    applyStimulus(32'hFE20AE23, 32'h108);
    checkDecode("sw", ADD, 32'hFFFF_FFFC, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sw.rs2", 32'(rs2Addr), 32'd2);

    // jal: unsupported opcode passes through flagged
    applyStimulus(32'h0000006F, 32'h10C);
    checkDecode("jal", ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("drained.valid", 32'(exValid), 32'd0);

    // Stall: A and B fill the buffer, C is held off
    exReady = 1'b0;
    applyStimulus(32'h00100093, 32'hA00);
    applyStimulus(32'h00200093, 32'hB00);
    checkOutput("stall.readyLow", 32'(instrReady), 32'd0);
    checkOutput("stall.holdA", pcOut, 32'hA00);
    instr      = 32'h00300093;
    pc         = 32'hC00;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall.stillA", pcOut, 32'hA00);
    checkOutput("stall.stillReadyLow", 32'(instrReady), 32'd0);
    exReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (exValid) seen.push_back(pcOut);
      accepted = instrValid && instrReady;
      @(posedge clk);
      #1;
      if (accepted) instrValid = 1'b0;
    end
    checkOutput("order.count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      checkOutput("order.first", seen[0], 32'hA00);
      checkOutput("order.second", seen[1], 32'hB00);
      checkOutput("order.third", seen[2], 32'hC00);
    end
    instrValid = 1'b0;

    // Flush with both entries held and a new word offered
    exReady = 1'b0;
    applyStimulus(32'h00100093, 32'hD00);
    applyStimulus(32'h00200093, 32'hD04);
    instr      = 32'h00300093;
    pc         = 32'hD08;
    instrValid = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    instrValid = 1'b0;
    checkOutput("flush.valid", 32'(exValid), 32'd0);
    checkOutput("flush.ready", 32'(instrReady), 32'd1);
    exReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush.noGhost", 32'(exValid), 32'd0);

    // Asynchronous reset in the middle of a stall
    exReady = 1'b0;
    applyStimulus(32'h40415113, 32'hE00);
    applyStimulus(32'h12345237, 32'hE04);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.valid", 32'(exValid), 32'd0);
    checkOutput("arst.ready", 32'(instrReady), 32'd1);
    checkOutput("arst.op", 32'(aluOp), ADD);
    checkOutput("arst.imm", imm, 32'd0);
    checkOutput("arst.pc", pcOut, 32'd0);
    checkOutput("arst.rd", 32'(rdAddr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst.stayEmpty", 32'(exValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
